// File: rtl/spine_pkg.sv
// Shared defaults and state type for the spine router switch allocators.
package spine_pkg;

  localparam int unsigned NUM_REQ_DEF = 11;
  localparam int unsigned DWIDTH_DEF  = 16;
  localparam int unsigned TAIL_BIT    = DWIDTH_DEF - 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester above last, wrapping at N.
module rr_pick
  import spine_pkg::*;
#(
  parameter int unsigned N  = NUM_REQ_DEF,
  parameter int unsigned IW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          any
);

  logic [IW-1:0] idx;
  logic          found;

  // Scan (last+1)..(last+N) modulo N; the modulo keeps every candidate below N.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(last) + k) % N);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spine_port_arbiter.sv
// Wormhole switch allocator for one spine output port: round-robin packet grants,
// same-cycle head pops, registered flit output and a stall watchdog on silent owners.
module spine_port_arbiter
  import spine_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned DWIDTH    = DWIDTH_DEF,
  parameter int unsigned IDW       = 4,
  parameter int unsigned STALL_MAX = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_pop,
  input  logic                      out_full,
  output logic [DWIDTH-1:0]         out_data,
  output logic                      out_valid,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      stall_abort
);

  localparam int unsigned TAIL = DWIDTH - 1;
  localparam int unsigned SW   = $clog2(STALL_MAX + 1);

  arb_state_t        state;
  logic [IDW-1:0]    last_grant;
  logic [IDW-1:0]    winner;
  logic              any_req;
  logic [SW-1:0]     stall_cnt;
  logic [DWIDTH-1:0] head;
  logic              gvalid;
  logic              transfer;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_pick (
    .req    (req_valid),
    .last   (last_grant),
    .winner (winner),
    .any    (any_req)
  );

  // Owner's head flit and valid; pop is one-hot by construction of the decode.
  always_comb begin
    head     = '0;
    gvalid   = 1'b0;
    req_pop  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        head   = req_data[i*DWIDTH +: DWIDTH];
        gvalid = req_valid[i];
      end
    end
    transfer = (state == LOCKED) && gvalid && !out_full;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_pop[i] = transfer && (grant_id == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= IDW'(NUM_REQ - 1);
      grant_id    <= '0;
      stall_cnt   <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      stall_abort <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      stall_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id  <= winner;
            stall_cnt <= '0;
            busy      <= 1'b1;
            state     <= LOCKED;
          end
        end
        LOCKED: begin
          if (transfer) begin
            out_data  <= head;
            out_valid <= 1'b1;
            stall_cnt <= '0;
            if (head[TAIL]) begin
              last_grant <= grant_id;
              grant_id   <= '0;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else if (!gvalid) begin
            // Only a silent owner ages the watchdog; output backpressure is legal.
            if (stall_cnt == SW'(STALL_MAX)) begin
              stall_abort <= 1'b1;
              last_grant  <= grant_id;
              grant_id    <= '0;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
